// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the synchronous FIFO family.
//   - FIFO_MODE_REG / FIFO_MODE_FWFT : read-mode selector values
//   - fifo_count_width(depth)        : bits needed to hold an occupancy of 0..depth
//   - fifo_ptr_width(depth)          : bits needed to address entries 0..depth-1
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Never less than one bit, even for a degenerate depth of 1.
  function automatic int fifo_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr
//   Single wrapping FIFO pointer. Counts 0..DEPTH-1 and wraps back to 0 by
//   explicit compare, so any DEPTH works (not only powers of two).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (pointer -> 0)
//   clr   - synchronous clear (pointer -> 0), wins over inc
//   inc   - advance the pointer by one entry
//   ptr   - current pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = fifo_ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty thresholds, overflow/underflow error pulses, synchronous
//   flush and a selectable read mode (registered or first-word-fall-through).
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   clr          - synchronous flush; overrides any access in the same cycle
//   w_en/data_in - write request and data
//   r_en         - read request
//   data_out     - read data (registered or FWFT, see FWFT parameter)
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - current occupancy
//   overflow     - one-cycle pulse after a write attempted while full
//   underflow    - one-cycle pulse after a read attempted while empty
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_MODE_REG
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               w_en,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               r_en,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic [fifo_count_width(DEPTH)-1:0] count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int CW = fifo_count_width(DEPTH);
  localparam int PW = fifo_ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Parameter sanity, caught at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL must be <= DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL must be < DEPTH");
  end
  if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode straight from the registered count: no extra latency.
  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (int'(count_reg) >= AF_LEVEL);
  assign almost_empty = (int'(count_reg) <= AE_LEVEL);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Accept decisions use the pre-edge full/empty. A flush suppresses both.
  assign wr_acc = w_en && !full  && !clr;
  assign rd_acc = r_en && !empty && !clr;

  fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_next = count_reg;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= w_en && full;
      underflow_reg <= r_en && empty;
    end
  end

  // Storage is deliberately left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic [DATA_WIDTH-1:0] hold_reg;

    // Remember whatever word is on display, so an empty FIFO (after the
    // last read or a flush) keeps showing it instead of stale storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_reg <= '0;
      end else if (!empty) begin
        hold_reg <= mem[rd_ptr];
      end
    end

    // Asynchronous storage read: the head word is visible without a request.
    assign data_out = empty ? hold_reg : mem[rd_ptr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (rd_acc) begin
        data_reg <= mem[rd_ptr];
      end
    end

    assign data_out = data_reg;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags. Two instances run side by side:
// dut0 uses the defaults (DEPTH 8, registered read) and dut1 uses DEPTH 5 in
// FWFT mode. The stimulus process updates a queue-based model and pushes the
// expected post-edge outputs; a separate monitor pops and compares them.
module tb_sync_fifo_flags;

  localparam int D0  = 8;
  localparam int D1  = 5;
  localparam int AF0 = 6;
  localparam int AF1 = 3;
  localparam int AE  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr0, w0, r0, clr1, w1, r1;
  logic [7:0] din0, din1, dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count0;
  logic [2:0] count1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(D0), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .w_en(w0), .data_in(din0), .r_en(r0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(D1), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .w_en(w1), .data_in(din1), .r_en(r1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  typedef struct {
    int         id;
    int         cnt;
    logic [7:0] data;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
    bit         ovf;
    bit         udf;
  } exp_t;

  exp_t       exq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: one data queue per instance plus the word last shown.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  function automatic int msize(input int id);
    return (id == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] mfront(input int id);
    return (id == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic mpop(input int id);
    if (id == 0) void'(mq0.pop_front());
    else         void'(mq1.pop_front());
  endtask

  task automatic mpush(input int id, input logic [7:0] v);
    if (id == 0) mq0.push_back(v);
    else         mq1.push_back(v);
  endtask

  task automatic mclear(input int id);
    if (id == 0) mq0.delete();
    else         mq1.delete();
  endtask

  task automatic model_step(input int id, input bit w, input bit r, input bit c,
                            input logic [7:0] d);
    int         depth;
    int         af_lvl;
    int         sz;
    bit         rd;
    bit         wr;
    bit         ovf;
    bit         udf;
    logic [7:0] front;
    logic [7:0] last;
    exp_t       e;
    depth  = (id == 0) ? D0 : D1;
    af_lvl = (id == 0) ? AF0 : AF1;
    last   = (id == 0) ? last0 : last1;
    sz     = msize(id);
    front  = (sz > 0) ? mfront(id) : 8'h00;
    ovf    = 1'b0;
    udf    = 1'b0;
    if (c) begin
      if (id == 1 && sz > 0) last = front;
      mclear(id);
    end else begin
      rd  = r && (sz > 0);
      wr  = w && (sz < depth);
      ovf = w && (sz == depth);
      udf = r && (sz == 0);
      if (id == 1) begin
        if (sz > 0) last = front;
      end else if (rd) begin
        last = front;
      end
      if (rd) mpop(id);
      if (wr) mpush(id, d);
    end
    sz     = msize(id);
    e.id   = id;
    e.cnt  = sz;
    e.data = (id == 1 && sz > 0) ? mfront(id) : last;
    e.full = (sz == depth);
    e.empty = (sz == 0);
    e.af   = (sz >= af_lvl);
    e.ae   = (sz <= AE);
    e.ovf  = ovf;
    e.udf  = udf;
    exq.push_back(e);
    if (id == 0) last0 = last;
    else         last1 = last;
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, id, act, exp, $time);
    end
  endtask

  // Monitor: every edge produces one output set per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exq.size() > 0) begin
        e = exq.pop_front();
        if (e.id == 0) begin
          chk("count", 0, 32'(count0), e.cnt);
          chk("data_out", 0, 32'(dout0), 32'(e.data));
          chk("full", 0, 32'(full0), 32'(e.full));
          chk("empty", 0, 32'(empty0), 32'(e.empty));
          chk("almost_full", 0, 32'(af0), 32'(e.af));
          chk("almost_empty", 0, 32'(ae0), 32'(e.ae));
          chk("overflow", 0, 32'(ovf0), 32'(e.ovf));
          chk("underflow", 0, 32'(udf0), 32'(e.udf));
        end else begin
          chk("count", 1, 32'(count1), e.cnt);
          chk("data_out", 1, 32'(dout1), 32'(e.data));
          chk("full", 1, 32'(full1), 32'(e.full));
          chk("empty", 1, 32'(empty1), 32'(e.empty));
          chk("almost_full", 1, 32'(af1), 32'(e.af));
          chk("almost_empty", 1, 32'(ae1), 32'(e.ae));
          chk("overflow", 1, 32'(ovf1), 32'(e.ovf));
          chk("underflow", 1, 32'(udf1), 32'(e.udf));
        end
        $display("txn t=%0t dut%0d count=%0d data_out=%02h ovf=%0b udf=%0b",
                 $time, e.id, e.cnt, e.data, e.ovf, e.udf);
      end
    end
  end

  task automatic cyc(input bit a_w, input bit a_r, input bit a_c, input logic [7:0] a_d,
                     input bit b_w, input bit b_r, input bit b_c, input logic [7:0] b_d);
    @(negedge clk);
    w0 = a_w; r0 = a_r; clr0 = a_c; din0 = a_d;
    w1 = b_w; r1 = b_r; clr1 = b_c; din1 = b_d;
    model_step(0, a_w, a_r, a_c, a_d);
    model_step(1, b_w, b_r, b_c, b_d);
  endtask

  task automatic c0(input bit w, input bit r, input bit c, input logic [7:0] d);
    cyc(w, r, c, d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic c1(input bit w, input bit r, input bit c, input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, w, r, c, d);
  endtask

  // Compares the asynchronous reset values while rst_n is held low.
  task automatic check_reset();
    chk("rst_count", 0, 32'(count0), 0);
    chk("rst_empty", 0, 32'(empty0), 1);
    chk("rst_full", 0, 32'(full0), 0);
    chk("rst_ae", 0, 32'(ae0), 1);
    chk("rst_af", 0, 32'(af0), 0);
    chk("rst_ovf", 0, 32'(ovf0), 0);
    chk("rst_udf", 0, 32'(udf0), 0);
    chk("rst_data", 0, 32'(dout0), 0);
    chk("rst_count", 1, 32'(count1), 0);
    chk("rst_empty", 1, 32'(empty1), 1);
    chk("rst_data", 1, 32'(dout1), 0);
    chk("rst_ovf", 1, 32'(ovf1), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    w0 = 0; r0 = 0; clr0 = 0; din0 = 0;
    w1 = 0; r1 = 0; clr1 = 0; din1 = 0;
    #1;
    check_reset();
    mq0.delete();
    mq1.delete();
    last0 = 8'h00;
    last1 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n, input int wprob);
    for (int i = 0; i < n; i++) begin
      cyc(($urandom_range(0, 99) < wprob), ($urandom_range(0, 99) < 100 - wprob),
          ($urandom_range(0, 39) == 0), 8'($urandom),
          ($urandom_range(0, 99) < wprob), ($urandom_range(0, 99) < 100 - wprob),
          ($urandom_range(0, 39) == 0), 8'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    w0 = 0; r0 = 0; clr0 = 0; din0 = 0;
    w1 = 0; r1 = 0; clr1 = 0; din1 = 0;
    #2;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // dut0: fill 0x11..0x88, then overflow attempt, then drain plus underflow.
    for (int i = 1; i <= 8; i++) c0(1, 0, 0, 8'(i * 17));
    c0(1, 0, 0, 8'h99);
    for (int i = 0; i < 9; i++) c0(0, 1, 0, 8'h00);
    // Steady state at count 4 with simultaneous access, wrapping pointers.
    for (int i = 0; i < 4; i++) c0(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) c0(1, 1, 0, 8'($urandom));
    // Full with both requests: read wins, write dropped.
    for (int i = 0; i < 4; i++) c0(1, 0, 0, 8'($urandom));
    c0(1, 1, 0, 8'h5A);
    for (int i = 0; i < 8; i++) c0(0, 1, 0, 8'h00);
    // Empty with both requests: write wins, read dropped.
    c0(1, 1, 0, 8'h3C);
    c0(1, 0, 0, 8'h3D);
    c0(1, 0, 0, 8'h3E);
    // Flush at count 3 with a write request pending.
    c0(1, 0, 1, 8'h77);
    c0(0, 1, 0, 8'h00);

    // dut1 (FWFT, depth 5): fill, idle, drain, then a second wrapping fill.
    for (int i = 0; i < 5; i++) c1(1, 0, 0, 8'(8'hA0 + i));
    c1(1, 0, 0, 8'hAF);
    for (int i = 0; i < 6; i++) c1(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) c1(1, (i > 1), 0, 8'(8'hB0 + i));
    c1(1, 1, 0, 8'hC0);
    for (int i = 0; i < 5; i++) c1(0, 1, 0, 8'h00);
    c1(1, 1, 0, 8'hC5);
    c1(0, 0, 1, 8'h00);

    random_run(120, 65);
    random_run(120, 35);

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'($urandom), 1, 0, 0, 8'($urandom));
    apply_reset();
    random_run(100, 50);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's single-clock FIFO. Adds:
- generic width/depth, including non-power-of-two depths
- occupancy count output
- programmable almost-full / almost-empty thresholds
- overflow / underflow error pulses
- synchronous flush
- selectable read mode: registered or first-word-fall-through (FWFT)

Sits between producer/consumer datapath stages in one clock domain.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2; any integer, not restricted to powers of two)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read, 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties FIFO
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset (rst_n=0, async):
  - write/read pointers = 0, count = 0
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0)
  - overflow=0, underflow=0, data_out=0
  - storage contents are not reset.
- Accept rules, both evaluated on the pre-edge state:
  - write accepted iff w_en && !full
  - read accepted iff r_en && !empty
- Simultaneous w_en && r_en:
  - normal case: both accepted, count unchanged.
  - full: read accepted, write dropped, overflow pulses.
  - empty: write accepted, read dropped, underflow pulses. No write-through bypass in either mode.
- Pointers: each increments by 1 on its accepted access and wraps from DEPTH-1 to 0 (explicit compare, no reliance on 2^n rollover).
- count: +1 on write only, -1 on read only, unchanged when both or neither occur. Registered.
- Flags: full, empty, almost_* are decoded combinationally from registered count, so they are valid in the same cycle as count. No extra latency.
- overflow/underflow are registered. Each is high exactly the one cycle after the offending edge, and never sticky.
- FWFT=0:
  - data_out is registered; it updates on the edge where a read is accepted with the word at the read pointer (1-cycle latency).
  - Otherwise data_out holds its last value.
- FWFT=1:
  - data_out continuously shows the word at the read pointer whenever !empty. An accepted read advances to the next word.
  - When empty, data_out holds the last value presented, and is 0 after reset.
- clr=1 at an edge:
  - pointers = 0, count = 0, error pulses cleared.
  - Any w_en/r_en in that cycle is ignored and raises no error.
  - clr has priority over all accesses.
- rst_n asserted mid-operation: immediate return to reset state. Data in flight is lost.
- Elaboration checks: AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH, DEPTH >= 2. Violations are reported by an elaboration-time error.

Decomposition:
- Shared package fifo_pkg: read-mode constants (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1) and a count-width helper function (clog2 of DEPTH+1). These are reused by later FIFO variants.
- One natural sub-module: fifo_ptr. It holds a single wrapping pointer with an increment enable and clr, instantiated twice (write, read).
- Storage array and flag decode stay inline in the top.

Test Plan:
- Default params, FWFT=0. After reset, write 0x11,0x22,...,0x88 (8 writes) -> full=1, count=8, almost_full asserted from count 6. A 9th write with 0x99 -> overflow high one cycle, contents unchanged.
- Read 8 times -> data_out sequence 0x11..0x88, each 1 cycle after its r_en edge. empty=1 after the last read; almost_empty asserted when count<=2. A 9th read -> underflow pulse, data_out holds 0x88.
- Simultaneous read/write at count=4 for 10 cycles -> count stays 4, output order preserved, pointers wrap past 7 with no corruption.
- DEPTH=5, FWFT=1: write 0xA0..0xA4 -> data_out=0xA0 the cycle after the first write with no r_en. Successive reads show 0xA1..0xA4; wrap is verified by a second fill.
- Full + w_en + r_en -> read accepted, count=DEPTH-1, overflow pulses. Empty + w_en + r_en -> count=1, underflow pulses.
- clr asserted at count=3 with w_en=1 -> count=0, empty=1, no overflow. rst_n pulsed low mid-burst -> all outputs return to reset values immediately, before the next clock edge.
